// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the EX stage and the iterative
// multiply/divide sequencer. The EX/MA pipeline side is the master and the
// sequencer is the slave.
interface muldiv_sequencer_if;
  logic        start_ex;
  logic [2:0]  alu_code_ex;
  logic [31:0] rs1_data_ex;
  logic [31:0] rs2_data_ex;
  logic [4:0]  rd_adr_ex;
  logic        kill_ex;
  logic        stall_ex;
  logic        done_md;
  logic        wbk_md;
  logic [4:0]  rd_adr_md;
  logic [31:0] rd_data_md;

  modport master (
    output start_ex, alu_code_ex, rs1_data_ex, rs2_data_ex, rd_adr_ex, kill_ex,
    input  stall_ex, done_md, wbk_md, rd_adr_md, rd_data_md
  );

  modport slave (
    input  start_ex, alu_code_ex, rs1_data_ex, rs2_data_ex, rd_adr_ex, kill_ex,
    output stall_ex, done_md, wbk_md, rd_adr_md, rd_data_md
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Operands are latched as magnitudes plus sign flags on start. A 32-step
// shift-add multiply or restoring divide follows, then a fix-up cycle applies
// signs and the RISC-V special cases. The result is presented for one cycle
// in DONE while stall_ex is released.
// Optional feature macro: MULDIV_EARLY_OUT_EN. When it is defined,
// divide-by-zero and signed overflow skip the loop entirely, and a multiply
// leaves the loop once no set multiplier bits remain.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_reg, state_next;

  // Multiply: acc = product, mcand = shifted multiplicand, mplier = remaining bits.
  // Divide:   acc = {remainder, dividend/quotient}, mcand[XLEN-1:0] = divisor.
  logic [2*XLEN-1:0] acc_reg, mcand_reg;
  logic [XLEN-1:0]   mplier_reg, rs1_raw_reg;
  logic [2:0]        op_reg;
  logic              neg_a_reg, neg_b_reg, div0_reg, ovf_reg;
  logic [4:0]        rd_adr_reg, rd_adr_md_reg;
  logic [XLEN-1:0]   rd_data_md_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              go, stall, done, skip_calc, mul_early;
  logic              signed_a, signed_b, neg_a, neg_b, div0_in, ovf_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] acc_step, mcand_step;
  logic [XLEN-1:0]   mplier_step, sub, quo, remv, res_fix;
  logic [XLEN:0]     part;
  logic [2*XLEN-1:0] prod;

  assign go = (state_reg == S_IDLE) && bus.start_ex && !bus.kill_ex;

  // Decode the incoming operation: operand signedness, magnitudes, special cases.
  always_comb begin
    signed_a = !((bus.alu_code_ex == 3'd3) || (bus.alu_code_ex == 3'd5) ||
                 (bus.alu_code_ex == 3'd7));
    signed_b = signed_a && (bus.alu_code_ex != 3'd2);
    neg_a    = signed_a && bus.rs1_data_ex[XLEN-1];
    neg_b    = signed_b && bus.rs2_data_ex[XLEN-1];
    abs_a    = neg_a ? -bus.rs1_data_ex : bus.rs1_data_ex;
    abs_b    = neg_b ? -bus.rs2_data_ex : bus.rs2_data_ex;
    div0_in  = bus.alu_code_ex[2] && (bus.rs2_data_ex == '0);
    ovf_in   = bus.alu_code_ex[2] && !bus.alu_code_ex[0] &&
               (bus.rs1_data_ex == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.rs2_data_ex == '1);
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign skip_calc = div0_in || ovf_in;
  assign mul_early = !op_reg[2] && (mplier_reg[XLEN-1:1] == '0);
`else
  assign skip_calc = 1'b0;
  assign mul_early = 1'b0;
`endif

  // One loop iteration: shift-add for multiply, compare/subtract for divide.
  always_comb begin
    acc_step    = acc_reg;
    mcand_step  = mcand_reg;
    mplier_step = mplier_reg;
    part        = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    // Only the low word is kept: when part >= divisor the difference fits.
    sub         = part[XLEN-1:0] - mcand_reg[XLEN-1:0];
    if (op_reg[2]) begin
      if (part >= {1'b0, mcand_reg[XLEN-1:0]})
        acc_step = {sub, acc_reg[XLEN-2:0], 1'b1};
      else
        acc_step = {part[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    end else begin
      if (mplier_reg[0])
        acc_step = acc_reg + mcand_reg;
      mcand_step  = mcand_reg << 1;
      mplier_step = mplier_reg >> 1;
    end
  end

  // Sign fix-up and result selection, with special cases overriding the loop.
  always_comb begin
    prod = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
    quo  = (neg_a_reg ^ neg_b_reg) ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    remv = neg_a_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    if (!op_reg[2])
      res_fix = (op_reg == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (div0_reg)
      res_fix = op_reg[1] ? rs1_raw_reg : '1;
    else if (ovf_reg)
      res_fix = op_reg[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else
      res_fix = op_reg[1] ? remv : quo;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic plus stall/done outputs; kill_ex always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (go) begin
          stall      = 1'b1;
          state_next = skip_calc ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        stall = 1'b1;
        if (bus.kill_ex)                         state_next = S_IDLE;
        else if ((cnt_reg == '0) || mul_early)   state_next = S_FIX;
      end
      S_FIX: begin
        stall      = 1'b1;
        state_next = bus.kill_ex ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done       = !bus.kill_ex;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latch, iteration registers and the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg        <= '0;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      rs1_raw_reg    <= '0;
      op_reg         <= '0;
      neg_a_reg      <= 1'b0;
      neg_b_reg      <= 1'b0;
      div0_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
      rd_adr_reg     <= '0;
      cnt_reg        <= '0;
      rd_adr_md_reg  <= '0;
      rd_data_md_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (go) begin
            op_reg      <= bus.alu_code_ex;
            neg_a_reg   <= neg_a;
            neg_b_reg   <= neg_b;
            div0_reg    <= div0_in;
            ovf_reg     <= ovf_in;
            rs1_raw_reg <= bus.rs1_data_ex;
            rd_adr_reg  <= bus.rd_adr_ex;
            cnt_reg     <= CNT_W'(XLEN - 1);
            if (bus.alu_code_ex[2]) begin
              acc_reg    <= {{XLEN{1'b0}}, abs_a};
              mcand_reg  <= {{XLEN{1'b0}}, abs_b};
              mplier_reg <= '0;
            end else begin
              acc_reg    <= '0;
              mcand_reg  <= {{XLEN{1'b0}}, abs_a};
              mplier_reg <= abs_b;
            end
          end
        end
        S_CALC: begin
          acc_reg    <= acc_step;
          mcand_reg  <= mcand_step;
          mplier_reg <= mplier_step;
          if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        end
        S_FIX: begin
          if (!bus.kill_ex) begin
            rd_data_md_reg <= res_fix;
            rd_adr_md_reg  <= rd_adr_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_ex   = stall;
  assign bus.done_md    = done;
  assign bus.wbk_md     = done && (rd_adr_md_reg != '0);
  assign bus.rd_adr_md  = rd_adr_md_reg;
  assign bus.rd_data_md = rd_data_md_reg;

endmodule
